reg_xfer_ctrl: RTL and testbench

- Sequencer that shares the internal 8-bit bus between NUM_REQ requesters wanting register-to-register moves.
- Drives one reg_op_e per bus register (NONE/ENABLE/LOAD).
- Grants requests round-robin and runs each move as a fixed two-cycle ENABLE/LOAD sequence, so no two registers ever drive the bus together.
- Sits between the control unit/microcode sources and the register file.

---
 rtl/reg_xfer_ctrl_pkg.sv | 27 ++
 rtl/reg_xfer_ctrl_rr_arbiter.sv | 55 +++++
 rtl/reg_xfer_ctrl.sv | 124 ++++++++++++
 tb/tb_reg_xfer_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_xfer_ctrl_pkg.sv
// rtl/reg_xfer_ctrl_pkg.sv - shared types and helpers for the register transfer sequencer
// Contents: reg_op_e (per-register bus operation), xfer_state_e (sequencer FSM),
//   COUNT_W (width of the optional move counter), is_nop() (detects a move with no effect).
package reg_xfer_ctrl_pkg;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    ENABLE = 2'd1,
    LOAD   = 2'd2
  } reg_op_e;

  typedef enum logic [1:0] {
    XS_IDLE,
    XS_PREP,
    XS_XFER,
    XS_DONE_NOP
  } xfer_state_e;

  localparam int unsigned COUNT_W = 16;

  // A move is a no-op when it targets its own source or names a register that does not exist.
  function automatic logic is_nop(input int unsigned src, input int unsigned dst,
                                  input int unsigned num_regs);
    return (src == dst) || (src >= num_regs) || (dst >= num_regs);
  endfunction

endpackage

// File: rtl/reg_xfer_ctrl_rr_arbiter.sv
// rtl/reg_xfer_ctrl_rr_arbiter.sv - round-robin arbiter with a rotating priority pointer
// Ports: clock_i, reset_i (async, active-high); req_i[N] request vector; advance_i moves
//   the pointer just past the current winner; grant_o one-hot winner; grant_idx_o its index.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;

  // First pass searches from the pointer upward, second pass wraps around to index 0.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i] && (IW'(i) >= ptr_q)) begin
        found       = 1'b1;
        grant_o[i]  = 1'b1;
        grant_idx_o = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i]) begin
        found       = 1'b1;
        grant_o[i]  = 1'b1;
        grant_idx_o = IW'(i);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (grant_idx_o == IW'(N - 1)) ? '0 : grant_idx_o + IW'(1);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/reg_xfer_ctrl.sv
// rtl/reg_xfer_ctrl.sv - sequences register-to-register moves over the shared 8-bit bus
// Ports: clock_i, reset_i (async, active-high); req_valid_i/req_src_i/req_dst_i per requester;
//   req_ready_o one-hot accept; reg_op_o per-register NONE/ENABLE/LOAD; busy_o; xfer_done_o
//   pulse with xfer_err_o marking a no-op move. Optional REG_XFER_COUNT_EN adds xfer_count_o.
module reg_xfer_ctrl
  import reg_xfer_ctrl_pkg::*;
#(
  parameter  int NUM_REGS = 4,
  parameter  int NUM_REQ  = 2,
  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int RIW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ-1:0][IDX_W-1:0]  req_src_i,
  input  logic [NUM_REQ-1:0][IDX_W-1:0]  req_dst_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output reg_op_e [NUM_REGS-1:0]         reg_op_o,
  output logic                           busy_o,
  output logic                           xfer_done_o,
  output logic                           xfer_err_o
`ifdef REG_XFER_COUNT_EN
  ,
  output logic [COUNT_W-1:0]             xfer_count_o
`endif
);

  xfer_state_e      state_q, state_d;
  logic [IDX_W-1:0] src_q, src_d;
  logic [IDX_W-1:0] dst_q, dst_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [NUM_REQ-1:0] grant;
  logic [RIW-1:0]     grant_idx;
  logic               accept;
  logic [IDX_W-1:0]   sel_src, sel_dst;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .req_i       (req_valid_i),
    .advance_i   (accept),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign req_ready_o = (state_q == XS_IDLE) ? grant : '0;
  assign accept      = |(req_valid_i & req_ready_o);
  assign sel_src     = req_src_i[grant_idx];
  assign sel_dst     = req_dst_i[grant_idx];

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    case (state_q)
      XS_IDLE: begin
        if (accept) begin
          src_d   = sel_src;
          dst_d   = sel_dst;
          state_d = is_nop(32'(sel_src), 32'(sel_dst), NUM_REGS) ? XS_DONE_NOP : XS_PREP;
        end
      end
      XS_PREP:     state_d = XS_XFER;
      XS_XFER:     state_d = XS_IDLE;
      XS_DONE_NOP: state_d = XS_IDLE;
      default:     state_d = XS_IDLE;
    endcase
  end

  // The done pulse is registered so it lands in the cycle after the move's last state.
  assign done_d = (state_q == XS_XFER) || (state_q == XS_DONE_NOP);
  assign err_d  = (state_q == XS_DONE_NOP);

  // Source stays enabled through XFER so the bus is stable at the destination's load edge.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_op_o[i] = NONE;
      if (((state_q == XS_PREP) || (state_q == XS_XFER)) && (IDX_W'(i) == src_q)) begin
        reg_op_o[i] = ENABLE;
      end else if ((state_q == XS_XFER) && (IDX_W'(i) == dst_q)) begin
        reg_op_o[i] = LOAD;
      end
    end
  end

  assign busy_o      = (state_q == XS_PREP) || (state_q == XS_XFER);
  assign xfer_done_o = done_q;
  assign xfer_err_o  = err_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= XS_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef REG_XFER_COUNT_EN
  logic [COUNT_W-1:0] cnt_q;

  // Counts at the XFER exit edge, the same edge that raises xfer_done for a real move.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (state_q == XS_XFER) begin
      cnt_q <= cnt_q + COUNT_W'(1);
    end
  end

  assign xfer_count_o = cnt_q;
`endif

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// tb/tb_reg_xfer_ctrl.sv - scoreboard bench for reg_xfer_ctrl with a small register-file model
module tb_reg_xfer_ctrl;
  import reg_xfer_ctrl_pkg::*;

  localparam int NR = 4;
  localparam int NQ = 2;
  localparam int IW = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NQ-1:0]           req_valid;
  logic [NQ-1:0][IW-1:0]   req_src;
  logic [NQ-1:0][IW-1:0]   req_dst;
  logic [NQ-1:0]           req_ready;
  reg_op_e [NR-1:0]        reg_op;
  logic                    busy, done, err;
`ifdef REG_XFER_COUNT_EN
  logic [15:0]             xfer_count;
`endif

  wire [7:0] rop = reg_op;

  reg_xfer_ctrl #(.NUM_REGS(NR), .NUM_REQ(NQ)) dut (
    .clock_i     (clk),
    .reset_i     (rst),
    .req_valid_i (req_valid),
    .req_src_i   (req_src),
    .req_dst_i   (req_dst),
    .req_ready_o (req_ready),
    .reg_op_o    (reg_op),
    .busy_o      (busy),
    .xfer_done_o (done),
    .xfer_err_o  (err)
`ifdef REG_XFER_COUNT_EN
    ,
    .xfer_count_o(xfer_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file: ENABLE copies a register into its output stage, LOAD captures the bus.
  logic [7:0] regs [NR];
  logic [7:0] outq [NR];
  logic [7:0] bus;
  logic       pre_we = 1'b0;
  logic [1:0] pre_idx = 2'd0;
  logic [7:0] pre_val = 8'h00;

  always @(posedge clk) begin
    if (pre_we) regs[pre_idx] <= pre_val;
    for (int j = 0; j < NR; j++) begin
      if (reg_op[j] == ENABLE) outq[j] <= regs[j];
      if (reg_op[j] == LOAD)   regs[j] <= bus;
    end
  end

  always_comb begin
    bus = 8'h00;
    for (int j = 0; j < NR; j++) begin
      if (reg_op[j] == ENABLE) bus = outq[j];
    end
  end

  typedef struct {
    int         dst;
    logic [7:0] val;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: bus exclusivity every cycle, and pops the scoreboard on each done pulse.
  always @(negedge clk) begin
    int ne;
    int nl;
    exp_t e;
    if (!rst) begin
      ne = 0;
      nl = 0;
      for (int j = 0; j < NR; j++) begin
        if (reg_op[j] == ENABLE) ne++;
        if (reg_op[j] == LOAD)   nl++;
      end
      check("single_enable", 32'(ne <= 1), 32'd1);
      check("single_load", 32'(nl <= 1), 32'd1);
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending move (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.cyc));
          check("done_err", 32'(err), 32'(e.err));
          check("dst_value", 32'(regs[e.dst]), 32'(e.val));
        end
      end else begin
        check("err_without_done", 32'(err), 32'd0);
      end
    end
  end

  task automatic preset(input logic [1:0] i, input logic [7:0] v);
    @(posedge clk); #1;
    pre_we = 1'b1; pre_idx = i; pre_val = v;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic wait_accept(input logic [NQ-1:0] exp_grant, input string name, output int acc);
    acc = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (|(req_ready & req_valid)) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no accept expected accept within 20 cycles", name);
    end else begin
      check(name, 32'(req_ready), 32'(exp_grant));
    end
  endtask

  task automatic push(input int d, input logic [7:0] v, input logic e, input int c);
    exp_t x;
    x.dst = d; x.val = v; x.err = e; x.cyc = c;
    exp_q.push_back(x);
  endtask

  task automatic run_move(input logic r, input logic [1:0] s, input logic [1:0] d,
                          input logic [7:0] v, input logic e);
    int a;
    @(posedge clk); #1;
    req_src[r] = s; req_dst[r] = d; req_valid[r] = 1'b1;
    wait_accept(r ? 2'b10 : 2'b01, "move_grant", a);
    if (a >= 0) push(32'(d), v, e, a + (e ? 2 : 3));
    @(posedge clk); #1 req_valid[r] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int a;
    int prev;
    rst = 1'b1;
    req_valid = '0;
    req_src = '0;
    req_dst = '0;

    // Reset state
    #2;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_reg_op", 32'(rop), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    preset(2'd0, 8'h10);
    preset(2'd1, 8'h5A);
    preset(2'd2, 8'h20);
    preset(2'd3, 8'h30);

    // Single move 1 -> 3
    @(posedge clk); #1;
    req_src[0] = 2'd1; req_dst[0] = 2'd3; req_valid[0] = 1'b1;
    wait_accept(2'b01, "single_grant", a);
    if (a >= 0) push(3, 8'h5A, 1'b0, a + 3);
    @(negedge clk);
    check("single_ready_drop", 32'(req_ready), 32'd0);
    check("single_prep_op", 32'(rop), 32'h04);
    check("single_prep_busy", 32'(busy), 32'd1);
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("single_xfer_op", 32'(rop), 32'h84);
    check("single_xfer_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("single_after_op", 32'(rop), 32'd0);
    check("single_after_busy", 32'(busy), 32'd0);

    // Round-robin with both requesters continuously valid
    do_reset();
    preset(2'd0, 8'h11);
    preset(2'd2, 8'h22);
    @(posedge clk); #1;
    req_src[0] = 2'd0; req_dst[0] = 2'd1;
    req_src[1] = 2'd2; req_dst[1] = 2'd3;
    req_valid = 2'b11;
    prev = -1;
    for (int k = 0; k < 4; k++) begin
      wait_accept((k % 2 == 1) ? 2'b10 : 2'b01, "rr_grant", a);
      if (a >= 0) push((k % 2 == 1) ? 3 : 1, (k % 2 == 1) ? 8'h22 : 8'h11, 1'b0, a + 3);
      if (prev >= 0 && a >= 0) check("rr_spacing", 32'(a - prev), 32'd3);
      prev = a;
    end
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (5) @(negedge clk);

    // No-op move 2 -> 2
    preset(2'd2, 8'h77);
    @(posedge clk); #1;
    req_src[0] = 2'd2; req_dst[0] = 2'd2; req_valid[0] = 1'b1;
    wait_accept(2'b01, "nop_grant", a);
    if (a >= 0) push(2, 8'h77, 1'b1, a + 2);
    @(negedge clk);
    check("nop_op", 32'(rop), 32'd0);
    check("nop_busy", 32'(busy), 32'd0);
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("nop_done_op", 32'(rop), 32'd0);
    repeat (2) @(negedge clk);

    // Reset during PREP of 0 -> 2
    preset(2'd0, 8'hC3);
    preset(2'd2, 8'h00);
    preset(2'd1, 8'h9D);
    @(posedge clk); #1;
    req_src[0] = 2'd0; req_dst[0] = 2'd2; req_valid[0] = 1'b1;
    wait_accept(2'b01, "rstmid_grant", a);
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 2'b00;
    #1;
    check("rstmid_op", 32'(rop), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rstmid_dst_kept", 32'(regs[2]), 32'h00);
    @(posedge clk); #1;
    req_src[0] = 2'd1; req_dst[0] = 2'd3;
    req_src[1] = 2'd3; req_dst[1] = 2'd0;
    req_valid = 2'b11;
    wait_accept(2'b01, "post_reset_grant", a);
    if (a >= 0) push(3, 8'h9D, 1'b0, a + 3);
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (4) @(negedge clk);

    // Request churn right after accept: 0 -> 3 from requester 1
    preset(2'd0, 8'h3C);
    preset(2'd1, 8'hE1);
    @(posedge clk); #1;
    req_src[1] = 2'd0; req_dst[1] = 2'd3; req_valid[1] = 1'b1;
    wait_accept(2'b10, "churn_grant", a);
    if (a >= 0) push(3, 8'h3C, 1'b0, a + 3);
    @(posedge clk); #1;
    req_src[1] = 2'd2; req_dst[1] = 2'd1; req_valid[1] = 1'b0;
    repeat (4) @(negedge clk);
    check("churn_other_reg", 32'(regs[1]), 32'hE1);

`ifdef REG_XFER_COUNT_EN
    do_reset();
    @(negedge clk);
    check("count_reset", 32'(xfer_count), 32'd0);
    preset(2'd0, 8'h01);
    run_move(1'b0, 2'd0, 2'd1, 8'h01, 1'b0);
    run_move(1'b0, 2'd0, 2'd2, 8'h01, 1'b0);
    run_move(1'b0, 2'd0, 2'd3, 8'h01, 1'b0);
    run_move(1'b0, 2'd1, 2'd1, 8'h01, 1'b1);
    check("count_three", 32'(xfer_count), 32'd3);
    @(negedge clk);
    force dut.cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.cnt_q;
    run_move(1'b0, 2'd0, 2'd2, 8'h01, 1'b0);
    check("count_wrap", 32'(xfer_count), 32'd0);
`endif

    // Drain the scoreboard
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
